// File: rtl/segre_pkg.sv
// segre_pkg: shared request/response types, sizes and arbiter states for the cache-to-memory path.
package segre_pkg;
    localparam int ARB_BUF_SIZE         = 16;
    localparam int ARB_PTR_SIZE         = 4;
    localparam int ADDR_SIZE            = 32;
    localparam int CACHE_LINE_SIZE_BITS = 128;

    typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_id_e;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} arb_state_e;

    typedef struct packed {
        logic [ADDR_SIZE-1:0]            addr;
        logic                            rd;
        logic                            wr;
        logic [CACHE_LINE_SIZE_BITS-1:0] data;
        cache_id_e                       cache_id;
    } cache_mem_req_t;
endpackage

// File: rtl/segre_arb_fifo.sv
// segre_arb_fifo: circular FIFO of cache_mem_req_t; BUF_SIZE must equal 2**PTR_SIZE so pointers wrap naturally.
module segre_arb_fifo
    import segre_pkg::*;
#(
    parameter int BUF_SIZE = ARB_BUF_SIZE,
    parameter int PTR_SIZE = ARB_PTR_SIZE
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              push_i,
    input  cache_mem_req_t    data_i,
    input  logic              pop_i,
    output cache_mem_req_t    data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PTR_SIZE:0] count_o
);
    cache_mem_req_t      buf_q [BUF_SIZE];
    logic [PTR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_SIZE:0]   count_q;
    logic                do_push, do_pop;

    assign full_o  = count_q == (PTR_SIZE+1)'(BUF_SIZE);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = buf_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_SIZE+1)'(do_push) - (PTR_SIZE+1)'(do_pop);
        end
    end

    // Entries need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) buf_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: queues icache/dcache requests and runs one memory transaction at a time.
// Optional SEGRE_ARB_DCACHE_PRIO_EN makes the dcache win every tie instead of round-robin.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int BUF_SIZE = ARB_BUF_SIZE,
    parameter int PTR_SIZE = ARB_PTR_SIZE
) (
    input  logic                            clk_i,
    input  logic                            rsn_i,
    input  logic                            ic_req_valid_i,
    output logic                            ic_req_ready_o,
    input  cache_mem_req_t                  ic_req_i,
    input  logic                            dc_req_valid_i,
    output logic                            dc_req_ready_o,
    input  cache_mem_req_t                  dc_req_i,
    output logic                            mem_req_valid_o,
    input  logic                            mem_req_ready_i,
    output cache_mem_req_t                  mem_req_o,
    input  logic                            mem_rsp_valid_i,
    input  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line_i,
    output logic                            ic_rsp_valid_o,
    output logic                            dc_rsp_valid_o,
    output logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_o,
    output logic [PTR_SIZE:0]               arb_count_o
);
    arb_state_e                      state_q, state_d;
    cache_mem_req_t                  req_q, push_data, pop_data;
    logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_q;
    logic                            ic_rsp_q, dc_rsp_q;
    logic                            full, empty, tie_dc, grant_dc, grant_ic, push, pop, rsp_hit;

    assign grant_dc       = dc_req_valid_i && (!ic_req_valid_i || tie_dc);
    assign grant_ic       = ic_req_valid_i && !grant_dc;
    // Readys are gated by reset so nothing looks accepted while the arbiter is held.
    assign ic_req_ready_o = rsn_i && grant_ic && !full;
    assign dc_req_ready_o = rsn_i && grant_dc && !full;
    assign push           = ic_req_ready_o || dc_req_ready_o;

    always_comb begin
        push_data          = grant_dc ? dc_req_i : ic_req_i;
        push_data.cache_id = grant_dc ? DCACHE : ICACHE;
    end

`ifdef SEGRE_ARB_DCACHE_PRIO_EN
    assign tie_dc = 1'b1;
`else
    cache_id_e last_grant_q;
    assign tie_dc = last_grant_q == ICACHE;
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) last_grant_q <= ICACHE;
        else if (push) last_grant_q <= grant_dc ? DCACHE : ICACHE;
    end
`endif

    segre_arb_fifo #(.BUF_SIZE(BUF_SIZE), .PTR_SIZE(PTR_SIZE)) u_fifo (
        .clk_i   (clk_i),
        .rsn_i   (rsn_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (pop_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (arb_count_o)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        rsp_hit = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (mem_req_ready_i) state_d = WAIT_RSP;
            WAIT_RSP: if (mem_rsp_valid_i) begin
                rsp_hit = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            rsp_line_q <= '0;
            ic_rsp_q   <= 1'b0;
            dc_rsp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (pop) req_q <= pop_data;
            if (rsp_hit) rsp_line_q <= mem_rsp_line_i;
            ic_rsp_q <= rsp_hit && req_q.cache_id == ICACHE;
            dc_rsp_q <= rsp_hit && req_q.cache_id == DCACHE;
        end
    end

    assign mem_req_valid_o = state_q == ISSUE;
    assign mem_req_o       = req_q;
    assign ic_rsp_valid_o  = ic_rsp_q;
    assign dc_rsp_valid_o  = dc_rsp_q;
    assign rsp_line_o      = rsp_line_q;
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed scenarios for the memory arbiter with hand-computed expectations.
module tb_segre_mem_arbiter;
    import segre_pkg::*;

    logic clk = 1'b0, rsn = 1'b0;
    logic ic_v = 1'b0, dc_v = 1'b0, mrdy = 1'b0, rspv = 1'b0;
    cache_mem_req_t ic_req = '0, dc_req = '0;
    logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_in = '0;
    logic ic_rdy, dc_rdy, mem_v, ic_rsp, dc_rsp;
    cache_mem_req_t mem_req;
    logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line;
    logic [ARB_PTR_SIZE:0] cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    segre_mem_arbiter dut (
        .clk_i           (clk),
        .rsn_i           (rsn),
        .ic_req_valid_i  (ic_v),
        .ic_req_ready_o  (ic_rdy),
        .ic_req_i        (ic_req),
        .dc_req_valid_i  (dc_v),
        .dc_req_ready_o  (dc_rdy),
        .dc_req_i        (dc_req),
        .mem_req_valid_o (mem_v),
        .mem_req_ready_i (mrdy),
        .mem_req_o       (mem_req),
        .mem_rsp_valid_i (rspv),
        .mem_rsp_line_i  (rsp_line_in),
        .ic_rsp_valid_o  (ic_rsp),
        .dc_rsp_valid_o  (dc_rsp),
        .rsp_line_o      (rsp_line),
        .arb_count_o     (cnt)
    );

    always @(posedge clk) begin
        if (ic_v) assert (ic_req.rd != ic_req.wr) else $error("illegal icache request: rd==wr");
        if (dc_v) assert (dc_req.rd != dc_req.wr) else $error("illegal dcache request: rd==wr");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic cache_mem_req_t mk(input logic [31:0] a, input logic w,
                                          input logic [CACHE_LINE_SIZE_BITS-1:0] d, input cache_id_e id);
        mk = '{addr: a, rd: !w, wr: w, data: d, cache_id: id};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rsn = 1'b0; ic_v = 1'b0; dc_v = 1'b0; mrdy = 1'b0; rspv = 1'b0;
        step();
        rsn = 1'b1;
    endtask

    // Waits for the issue, checks it, acks it, then returns one response and checks the routed pulse.
    task automatic serve(input string name, input cache_id_e eid, input logic [31:0] eaddr,
                         input logic [CACHE_LINE_SIZE_BITS-1:0] line, input bit chk_line);
        int n = 0;
        mrdy = 1'b1;
        while (mem_v !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (mem_v !== 1'b1) begin
            failures++;
            mrdy = 1'b0;
            $display("FAIL %s timeout: mem_req_valid_o stayed low for 40 cycles", name);
            return;
        end
        if (mem_req.cache_id !== eid || mem_req.addr !== eaddr) begin
            failures++;
            $display("FAIL %s issue: got id=%0d addr=%h, expected id=%0d addr=%h", name, mem_req.cache_id, mem_req.addr, eid, eaddr);
        end
        step();
        mrdy = 1'b0; rspv = 1'b1; rsp_line_in = line;
        step();
        rspv = 1'b0;
        checks++;
        if (ic_rsp !== (eid == ICACHE) || dc_rsp !== (eid == DCACHE) || (chk_line && rsp_line !== line)) begin
            failures++;
            $display("FAIL %s response: got ic=%b dc=%b line=%h, expected id=%0d line=%h", name, ic_rsp, dc_rsp, rsp_line, eid, line);
        end
    endtask

    task automatic test_reset();
        rsn = 1'b0; ic_v = 1'b1; dc_v = 1'b1; mrdy = 1'b1; rspv = 1'b1;
        ic_req = mk(32'h10, 1'b0, '0, ICACHE);
        dc_req = mk(32'h20, 1'b0, '0, DCACHE);
        #1;
        checks++;
        if ({ic_rdy, dc_rdy} !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b expected 00", {ic_rdy, dc_rdy}); end
        step();
        checks++;
        if ({mem_v, ic_rsp, dc_rsp} !== 3'b000) begin failures++; $display("FAIL reset_valids: got %b expected 000", {mem_v, ic_rsp, dc_rsp}); end
        checks++;
        if (cnt !== '0 || mem_req !== '0 || rsp_line !== '0) begin failures++; $display("FAIL reset_data: got count=%0d req=%h line=%h expected all 0", cnt, mem_req, rsp_line); end
        ic_v = 1'b0; dc_v = 1'b0; mrdy = 1'b0; rspv = 1'b0;
        rsn = 1'b1;
        step();
        checks++;
        if (cnt !== '0 || mem_v !== 1'b0) begin failures++; $display("FAIL reset_release: got count=%0d mem_v=%b expected 0 0", cnt, mem_v); end
    endtask

    task automatic test_single_read();
        logic [CACHE_LINE_SIZE_BITS-1:0] line = {4{32'hDEADBEEF}};
        do_reset();
        ic_req = mk(32'h100, 1'b0, '0, DCACHE);
        ic_v = 1'b1; mrdy = 1'b1;
        #1;
        checks++;
        if ({ic_rdy, dc_rdy} !== 2'b10) begin failures++; $display("FAIL read_accept: got ic/dc ready %b expected 10", {ic_rdy, dc_rdy}); end
        step();
        ic_v = 1'b0;
        checks++;
        if (mem_v !== 1'b0) begin failures++; $display("FAIL read_cycle1: got mem_v=%b expected 0", mem_v); end
        step();
        checks++;
        if (mem_v !== 1'b1 || mem_req.cache_id !== ICACHE || mem_req.rd !== 1'b1 || mem_req.wr !== 1'b0 || mem_req.addr !== 32'h100)
            begin failures++; $display("FAIL read_issue: got v=%b id=%0d rd=%b wr=%b addr=%h expected 1 0 1 0 100", mem_v, mem_req.cache_id, mem_req.rd, mem_req.wr, mem_req.addr); end
        step();
        mrdy = 1'b0;
        checks++;
        if (mem_v !== 1'b0) begin failures++; $display("FAIL read_wait: got mem_v=%b expected 0", mem_v); end
        step();
        step();
        rspv = 1'b1; rsp_line_in = line;
        step();
        rspv = 1'b0;
        checks++;
        if (ic_rsp !== 1'b1 || dc_rsp !== 1'b0 || rsp_line !== line) begin failures++; $display("FAIL read_rsp: got ic=%b dc=%b line=%h expected 1 0 %h", ic_rsp, dc_rsp, rsp_line, line); end
        step();
        checks++;
        if (ic_rsp !== 1'b0 || dc_rsp !== 1'b0 || cnt !== '0) begin failures++; $display("FAIL read_pulse_end: got ic=%b dc=%b count=%0d expected 0 0 0", ic_rsp, dc_rsp, cnt); end
    endtask

    task automatic test_tie();
        do_reset();
        ic_req = mk(32'h300, 1'b0, '0, DCACHE);
        dc_req = mk(32'h400, 1'b0, '0, ICACHE);
        ic_v = 1'b1; dc_v = 1'b1;
        #1;
        checks++;
        if ({ic_rdy, dc_rdy} !== 2'b01) begin failures++; $display("FAIL tie_first: got ic/dc ready %b expected 01", {ic_rdy, dc_rdy}); end
        step();
        dc_req = mk(32'h440, 1'b0, '0, ICACHE);
        #1;
`ifdef SEGRE_ARB_DCACHE_PRIO_EN
        checks++;
        if ({ic_rdy, dc_rdy} !== 2'b01) begin failures++; $display("FAIL tie_second: got ic/dc ready %b expected 01", {ic_rdy, dc_rdy}); end
        step();
        dc_v = 1'b0;
        #1;
        checks++;
        if (ic_rdy !== 1'b1) begin failures++; $display("FAIL tie_third: got ic ready %b expected 1", ic_rdy); end
        step();
        ic_v = 1'b0;
        serve("tie_q0", DCACHE, 32'h400, 128'h1, 1'b1);
        serve("tie_q1", DCACHE, 32'h440, 128'h2, 1'b1);
        serve("tie_q2", ICACHE, 32'h300, 128'h3, 1'b1);
`else
        checks++;
        if ({ic_rdy, dc_rdy} !== 2'b10) begin failures++; $display("FAIL tie_second: got ic/dc ready %b expected 10", {ic_rdy, dc_rdy}); end
        step();
        ic_v = 1'b0; dc_v = 1'b0;
        serve("tie_q0", DCACHE, 32'h400, 128'h1, 1'b1);
        serve("tie_q1", ICACHE, 32'h300, 128'h2, 1'b1);
`endif
    endtask

    task automatic test_full_stall();
        int acc = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            dc_req = mk(32'h1000 + 32'(i * 64), 1'b0, '0, ICACHE);
            dc_v = 1'b1;
            #1;
            if (dc_rdy === 1'b1) acc++;
            step();
        end
        checks++;
        if (acc != 17) begin failures++; $display("FAIL stall_accepted: got %0d expected 17", acc); end
        #1;
        checks++;
        if (cnt !== 5'd16 || dc_rdy !== 1'b0) begin failures++; $display("FAIL stall_full: got count=%0d ready=%b expected 16 0", cnt, dc_rdy); end
        dc_v = 1'b0;
        for (int i = 0; i < 17; i++)
            serve($sformatf("stall_drain%0d", i), DCACHE, 32'h1000 + 32'(i * 64), 128'(i + 100), 1'b1);
        step();
        step();
        checks++;
        if (cnt !== '0 || mem_v !== 1'b0) begin failures++; $display("FAIL stall_empty: got count=%0d mem_v=%b expected 0 0", cnt, mem_v); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ic_req = mk(32'h500 + 32'(i * 64), 1'b0, '0, ICACHE);
            ic_v = 1'b1;
            step();
        end
        ic_v = 1'b0; mrdy = 1'b1;
        step();
        mrdy = 1'b0;
        checks++;
        if (cnt !== 5'd3 || mem_v !== 1'b0) begin failures++; $display("FAIL mid_setup: got count=%0d mem_v=%b expected 3 0", cnt, mem_v); end
        rsn = 1'b0;
        #1;
        checks++;
        if (cnt !== '0 || mem_v !== 1'b0 || mem_req !== '0 || rsp_line !== '0 || ic_rsp !== 1'b0 || dc_rsp !== 1'b0)
            begin failures++; $display("FAIL mid_reset: got count=%0d mem_v=%b req=%h line=%h expected all 0", cnt, mem_v, mem_req, rsp_line); end
        step();
        rsn = 1'b1; rspv = 1'b1; rsp_line_in = '1;
        step();
        rspv = 1'b0;
        checks++;
        if (ic_rsp !== 1'b0 || dc_rsp !== 1'b0 || mem_v !== 1'b0) begin failures++; $display("FAIL mid_late_rsp: got ic=%b dc=%b mem_v=%b expected 0 0 0", ic_rsp, dc_rsp, mem_v); end
        ic_req = mk(32'h600, 1'b0, '0, ICACHE);
        ic_v = 1'b1;
        step();
        ic_v = 1'b0;
        serve("mid_new", ICACHE, 32'h600, {4{32'h12345678}}, 1'b1);
    endtask

    task automatic test_write();
        logic [CACHE_LINE_SIZE_BITS-1:0] line = {16{8'hA5}};
        do_reset();
        dc_req = mk(32'h2000, 1'b1, line, ICACHE);
        dc_v = 1'b1;
        #1;
        checks++;
        if (dc_rdy !== 1'b1) begin failures++; $display("FAIL write_accept: got ready=%b expected 1", dc_rdy); end
        step();
        dc_v = 1'b0;
        step();
        checks++;
        if (mem_v !== 1'b1 || mem_req.wr !== 1'b1 || mem_req.rd !== 1'b0 || mem_req.data !== line)
            begin failures++; $display("FAIL write_issue: got v=%b wr=%b rd=%b data=%h expected 1 1 0 %h", mem_v, mem_req.wr, mem_req.rd, mem_req.data, line); end
        serve("write_ack", DCACHE, 32'h2000, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_full_stall();
        test_reset_mid();
        test_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
Shares the single main-memory port between the instruction cache and the data cache. Accepts one cache_mem_req_t per cycle from either cache and buffers it in an ARB_BUF_SIZE-entry FIFO. Issues queued requests to memory one at a time and routes each response back to the originating cache by cache_id. Sits between segre_icache/segre_dcache and the memory model.

Parameters:
BUF_SIZE, ARB_BUF_SIZE (16), FIFO depth; power of two.
PTR_SIZE, ARB_PTR_SIZE (4), FIFO pointer width = clog2(BUF_SIZE).

Ports:
clk_i  in  1  clock
rsn_i  in  1  asynchronous active-low reset
ic_req_valid_i  in  1  icache request valid
ic_req_ready_o  out  1  icache request accepted this cycle
ic_req_i  in  $bits(cache_mem_req_t)  icache request
dc_req_valid_i  in  1  dcache request valid
dc_req_ready_o  out  1  dcache request accepted this cycle
dc_req_i  in  $bits(cache_mem_req_t)  dcache request
mem_req_valid_o  out  1  request to memory valid
mem_req_ready_i  in  1  memory accepts request
mem_req_o  out  $bits(cache_mem_req_t)  request to memory
mem_rsp_valid_i  in  1  memory response/ack valid
mem_rsp_line_i  in  CACHE_LINE_SIZE_BITS  read data
ic_rsp_valid_o  out  1  one-cycle response pulse to icache
dc_rsp_valid_o  out  1  one-cycle response pulse to dcache
rsp_line_o  out  CACHE_LINE_SIZE_BITS  response line, shared by both caches
arb_count_o  out  PTR_SIZE+1  FIFO occupancy

Behaviour:
- Reset (async, rsn_i low): FIFO empty, state IDLE, last_grant=ICACHE. All outputs 0, including readys and arb_count_o.
- Enqueue: at most one request per cycle.
  - Grant is combinational from the valids. A tie uses round-robin: grant the cache not in last_grant. last_grant updates only on an actual enqueue.
  - x_req_ready_o = granted && !full. No enqueue when full, even if a pop occurs in the same cycle.
  - Stored cache_id is forced from the port the request arrived on; the input field is ignored.
- FSM states arb_state_e: IDLE, ISSUE, WAIT_RSP.
  - IDLE: if the FIFO is non-empty, pop the head into the request register and go to ISSUE.
  - ISSUE: mem_req_valid_o=1 and mem_req_o holds stable until mem_req_ready_i is high, then go to WAIT_RSP.
  - WAIT_RSP: on mem_rsp_valid_i, register mem_rsp_line_i into rsp_line_o, pulse ic_rsp_valid_o or dc_rsp_valid_o (per the held cache_id) on the next cycle, and return to IDLE.
  - mem_rsp_valid_i in IDLE or ISSUE is ignored.
- Writes (wr=1) are also completed by mem_rsp_valid_i. rsp_line_o is then don't-care.
- rd==wr is illegal; the bench flags it with an assertion.
- Latency, empty arbiter: accept at cycle 0, mem_req_valid_o at cycle 2. Response valid at cycle k gives x_rsp_valid_o at k+1.
  - Next pop occurs at k+1; back-to-back issue period is ≥3 cycles.
- Capacity: FIFO plus one held request gives BUF_SIZE+1 accepted requests before stall.
- Push and pop in the same cycle: occupancy unchanged. Pointers wrap modulo BUF_SIZE.
- Only one memory transaction is outstanding at a time. Memory order equals FIFO order.
- Reset mid-transaction drops all queued and in-flight requests. A late mem_rsp_valid_i is ignored.

Optional Feature:
SEGRE_ARB_DCACHE_PRIO_EN
- Defined: ties always grant DCACHE, and last_grant is unused.
- Undefined: round-robin as above.

Decomposition:
- segre_pkg holds: cache_mem_req_t, cache_id_e, ARB_BUF_SIZE, ARB_PTR_SIZE, CACHE_LINE_SIZE_BITS, and the new arb_state_e.
- Sub-module segre_arb_fifo: a generic FIFO of cache_mem_req_t with push, pop, full, empty and count.
- segre_mem_arbiter keeps the grant logic and the FSM.

Test Plan:
1. Single icache read of addr 0x100; mem_req_ready_i=1; mem responds 3 cycles after issue with line 0xDEADBEEF_x4.
   - mem_req_valid_o at cycle 2 with cache_id=ICACHE, rd=1.
   - ic_rsp_valid_o one-cycle pulse with rsp_line_o=0xDEADBEEF_x4.
   - dc_rsp_valid_o stays 0.
2. Both caches valid for 2 consecutive cycles after reset.
   - Enqueue order is DCACHE, ICACHE (round-robin from last_grant=ICACHE).
   - mem_req_o.cache_id follows the same order.
3. mem_req_ready_i held 0; dcache streams 20 requests.
   - Exactly 17 accepted.
   - arb_count_o=16 and dc_req_ready_o=0 thereafter.
   - After releasing ready and acking all, the 17 are issued in order and arb_count_o returns to 0.
4. Reset asserted in WAIT_RSP with 3 queued.
   - All outputs 0 immediately.
   - mem_rsp_valid_i one cycle later produces no rsp pulse.
   - A new icache request then completes normally.
5. dcache write to addr 0x2000 with line 0xA5 repeated.
   - mem_req_o.wr=1 and the line matches.
   - Ack produces dc_rsp_valid_o pulse.
6. With SEGRE_ARB_DCACHE_PRIO_EN, both caches valid for 2 cycles.
   - DCACHE is granted both times; icache is accepted on the third cycle.
